nbits_seq_divider: RTL and testbench

//  Iterative unsigned restoring divider: the inverse of the N-bit adder datapath.

---
 rtl/nbits_seq_divider.sv | 138 +++++++++++++
 tb/tb_nbits_seq_divider.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nbits_seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Optional `DIV_ZERO_FAST_EN: a zero divisor completes in one cycle without iterating.
module nbits_seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  dvd_q, dvd_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_pend_q, dbz_pend_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    rem_shift;
    logic [N:0]    diff;
    logic          qbit;
    logic          last_iter;
    logic          accept;
    logic          fast_zero;

    // Trial subtract is N+1 bits wide so a divisor above 2^(N-1) cannot overflow it.
    always_comb begin
        accept    = start && (state_q != S_CALC);
`ifdef DIV_ZERO_FAST_EN
        fast_zero = accept && (b == '0);
`else
        fast_zero = 1'b0;
`endif
        rem_shift = {rem_q, dvd_q[N-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        qbit      = ~diff[N];
        last_iter = (cnt_q == CW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            q_q        <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
            dbz_pend_q <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            q_q        <= q_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            dbz_pend_q <= dbz_pend_d;
            dbz_q      <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (fast_zero) begin
                    state_d = S_DONE;
                end else if (accept) begin
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC:  state_d = last_iter ? S_DONE : S_CALC;
            default: state_d = S_IDLE;
        endcase
    end

    // The dividend register doubles as the quotient accumulator: bits shift out the
    // top into the remainder while quotient bits enter at the bottom.
    always_comb begin
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        q_d        = q_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        dbz_pend_d = dbz_pend_q;
        dbz_d      = dbz_q;
        if (accept) begin
            dvd_d      = a;
            dvs_d      = b;
            rem_d      = '0;
            cnt_d      = '0;
            dbz_pend_d = (b == '0);
            if (fast_zero) begin
                q_d   = '1;
                r_d   = a;
                dbz_d = 1'b1;
            end
        end else if (state_q == S_CALC) begin
            rem_d = qbit ? diff[N-1:0] : rem_shift[N-1:0];
            dvd_d = {dvd_q[N-2:0], qbit};
            cnt_d = cnt_q + 1'b1;
            if (last_iter) begin
                q_d   = {dvd_q[N-2:0], qbit};
                r_d   = qbit ? diff[N-1:0] : rem_shift[N-1:0];
                dbz_d = dbz_pend_q;
            end
        end
    end

    always_comb begin
        busy        = (state_q == S_CALC);
        done        = (state_q == S_DONE);
        q           = q_q;
        r           = r_q;
        div_by_zero = dbz_q;
    end
endmodule

// File: tb/tb_nbits_seq_divider.sv
// Self-checking bench for nbits_seq_divider (N=8): vector table, corner sequences,
// random sweep; results checked by a scoreboard queue popped on every done pulse.
module tb_nbits_seq_divider;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy, done, div_by_zero;
    logic [N-1:0] q, r;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
    } vec_t;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[10];

    nbits_seq_divider #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .r(r), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_lat(input logic [N-1:0] bv);
`ifdef DIV_ZERO_FAST_EN
        if (bv == '0) return 0;
`endif
        return N;
    endfunction

    function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv);
        exp_t e;
        if (bv == '0) begin
            e.q = '1; e.r = av; e.dbz = 1'b1;
        end else begin
            e.q = av / bv; e.r = av % bv; e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn q=%0d r=%0d dbz=%0b (exp q=%0d r=%0d dbz=%0b)",
                         q, r, div_by_zero, e.q, e.r, e.dbz);
                chk("q", int'(q), int'(e.q));
                chk("r", int'(r), int'(e.r));
                chk("div_by_zero", int'(div_by_zero), int'(e.dbz));
            end
        end
    end

    // Drive start across one rising edge; push the expectation only if it should be taken.
    task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv, input bit accepted);
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        if (accepted) sb.push_back(model(av, bv));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count negedges until done is seen (0 if already high); also counts busy cycles.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0; busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int lat, bc, pre;
        tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
        tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
        tbl[3] = '{8'd200, 8'd200, 8'd1,   8'd0,   1'b0};
        tbl[4] = '{8'd255, 8'd128, 8'd1,   8'd127, 1'b0};
        tbl[5] = '{8'd37,  8'd0,   8'hFF,  8'd37,  1'b1};
        tbl[6] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
        tbl[7] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};
        tbl[8] = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0};
        tbl[9] = '{8'd254, 8'd127, 8'd2,   8'd0,   1'b0};

        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q", int'(q), 0);
        chk("rst_r", int'(r), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            start = 1'b1; a = tbl[i].a; b = tbl[i].b;
            sb.push_back('{tbl[i].q, tbl[i].r, tbl[i].dbz});
            @(negedge clk);
            start = 1'b0;
            wait_done(lat, bc);
            chk($sformatf("latency_%0d", i), lat, exp_lat(tbl[i].b));
            chk($sformatf("busy_cycles_%0d", i), bc, exp_lat(tbl[i].b));
        end

        // Results hold after done.
        repeat (3) @(negedge clk);
        chk("hold_q", int'(q), 2);
        chk("hold_r", int'(r), 0);
        chk("idle_busy", int'(busy), 0);

        // Start while busy is ignored.
        issue(8'd50, 8'd3, 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'd9; b = 8'd9;
        @(negedge clk);
        start = 1'b0;
        chk("busy_during_ignored", int'(busy), 1);
        pre = 3;
        wait_done(lat, bc);
        chk("ignored_latency", pre + lat, N);

        // Back-to-back start in the done cycle.
        start = 1'b1; a = 8'd81; b = 8'd9;
        sb.push_back(model(8'd81, 8'd9));
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", int'(busy), 1);
        wait_done(lat, bc);
        chk("b2b_latency", lat, N);

        // Reset in the middle of an operation.
        issue(8'd100, 8'd7, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        sb.delete();
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_q", int'(q), 0);
        chk("midrst_r", int'(r), 0);
        @(negedge clk);
        rst = 1'b0;
        issue(8'd250, 8'd13, 1'b1);
        wait_done(lat, bc);
        chk("post_rst_latency", lat, N);

        // Random sweep against the a/b, a%b model.
        for (int k = 0; k < 200; k++) begin
            logic [N-1:0] ra, rb;
            ra = N'($urandom);
            rb = (k % 25 == 0) ? '0 : N'($urandom);
            issue(ra, rb, 1'b1);
            wait_done(lat, bc);
            chk("rand_latency", lat, exp_lat(rb));
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
